// File: rtl/unet_ctrl_pkg.sv
// Shared types and constants for the UNET conv2d layer sequencer.
package unet_ctrl_pkg;

  localparam int unsigned MAX_LAYERS = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned DESC_W     = 52;

  // Bit offsets of each field inside a packed descriptor word.
  localparam int unsigned HEIGHT_LSB = 0;
  localparam int unsigned WIDTH_LSB  = 7;
  localparam int unsigned KSIZE_LSB  = 14;
  localparam int unsigned PAD_LSB    = 16;
  localparam int unsigned FOFS_LSB   = 18;
  localparam int unsigned INCH_LSB   = 38;
  localparam int unsigned OUTCH_LSB  = 45;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StNext,
    StDone
  } state_e;

  // Field order is MSB first so the struct overlays the packed descriptor word.
  typedef struct packed {
    logic [6:0]  out_channels;
    logic [6:0]  in_channels;
    logic [19:0] filter_offset;
    logic [1:0]  padding;
    logic [1:0]  kernel_size;
    logic [6:0]  width;
    logic [6:0]  height;
  } desc_t;

endpackage

// File: rtl/unet_layer_desc_table.sv
// Layer descriptor register file: one write port, combinational read, no reset.
module unet_layer_desc_table #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4,
  parameter int unsigned Width = 52
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/unet_conv_layer_sequencer.sv
// Walks conv2d through a programmed list of layers, one start/done handshake per layer,
// alternating the ping-pong buffer select between layers.
module unet_conv_layer_sequencer
  import unet_ctrl_pkg::*;
#(
  parameter int unsigned MaxLayers = MAX_LAYERS,
  parameter int unsigned IdxW      = IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [IdxW-1:0]   cfg_addr_i,
  input  logic [DESC_W-1:0] cfg_data_i,
  input  logic [IdxW:0]     num_layers_i,
  input  logic              run_start_i,
  input  logic              run_abort_i,
  output logic              run_busy_o,
  output logic              run_done_o,
  output logic              run_err_o,
  output logic              run_aborted_o,
  output logic [IdxW-1:0]   layer_idx_o,
  output logic              buf_sel_o,
  output logic              conv_start_o,
  input  logic              conv_done_i,
  output logic [6:0]        height_o,
  output logic [6:0]        width_o,
  output logic [1:0]        kernel_size_o,
  output logic [1:0]        padding_o,
  output logic [19:0]       filter_offset_o,
  output logic [6:0]        in_channels_o,
  output logic [6:0]        out_channels_o
);

  localparam logic [IdxW:0] MaxCnt = (IdxW + 1)'(MaxLayers);
  localparam logic [IdxW:0] OneCnt = (IdxW + 1)'(1);

  state_e            state_q, state_d;
  logic [IdxW:0]     num_q, num_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              buf_q, buf_d;
  logic              err_q, err_d;
  logic              aborted_q, aborted_d;
  logic              abort_q, abort_d;
  desc_t             cfg_q, cfg_d;
  logic [DESC_W-1:0] rd_data;
  logic              tbl_we;

  assign tbl_we = cfg_we_i && (state_q == StIdle);

  unet_layer_desc_table #(
    .Depth (MaxLayers),
    .AddrW (IdxW),
    .Width (DESC_W)
  ) u_desc_table (
    .clk_i   (clk_i),
    .we_i    (tbl_we),
    .waddr_i (cfg_addr_i),
    .wdata_i (cfg_data_i),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    err_d        = err_q;
    aborted_d    = aborted_q;
    abort_d      = abort_q;
    cfg_d        = cfg_q;
    conv_start_o = 1'b0;
    run_done_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_start_i) begin
          num_d     = num_layers_i;
          err_d     = 1'b0;
          aborted_d = 1'b0;
          abort_d   = 1'b0;
          idx_d     = '0;
          buf_d     = 1'b0;
          if (num_layers_i == '0 || num_layers_i > MaxCnt) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (run_abort_i) begin
          abort_d = 1'b1;
          state_d = StDone;
        end else begin
          cfg_d   = desc_t'(rd_data);
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (run_abort_i) begin
          abort_d = 1'b1;
          state_d = StDone;
        end else begin
          conv_start_o = 1'b1;
          state_d      = StWait;
        end
      end
      StWait: begin
        // Abort is only remembered here; the layer in flight always completes.
        if (run_abort_i) begin
          abort_d = 1'b1;
        end
        if (conv_done_i) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (abort_q || run_abort_i) begin
          abort_d = 1'b1;
          state_d = StDone;
        end else if ({1'b0, idx_q} == num_q - OneCnt) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          buf_d   = ~buf_q;
          state_d = StLoad;
        end
      end
      StDone: begin
        run_done_o = 1'b1;
        aborted_d  = abort_q;
        abort_d    = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (conv_done_i && state_q != StWait) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      num_q     <= '0;
      idx_q     <= '0;
      buf_q     <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
      abort_q   <= abort_d;
      cfg_q     <= cfg_d;
    end
  end

  assign run_busy_o      = (state_q != StIdle);
  assign run_err_o       = err_q;
  assign run_aborted_o   = aborted_q;
  assign layer_idx_o     = idx_q;
  assign buf_sel_o       = buf_q;
  assign height_o        = cfg_q.height;
  assign width_o         = cfg_q.width;
  assign kernel_size_o   = cfg_q.kernel_size;
  assign padding_o       = cfg_q.padding;
  assign filter_offset_o = cfg_q.filter_offset;
  assign in_channels_o   = cfg_q.in_channels;
  assign out_channels_o  = cfg_q.out_channels;

endmodule

// File: tb/tb_unet_conv_layer_sequencer.sv
// Self-checking bench: random descriptors, a table model and a conv2d responder.
module tb_unet_conv_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [51:0] cfg_data = '0;
  logic [4:0]  num_layers = '0;
  logic        run_start = 1'b0;
  logic        run_abort = 1'b0;
  logic        conv_done = 1'b0;
  logic        run_busy, run_done, run_err, run_aborted, buf_sel, conv_start;
  logic [3:0]  layer_idx;
  logic [6:0]  height, width, in_ch, out_ch;
  logic [1:0]  ksize, pad;
  logic [19:0] fofs;

  logic [51:0] tbl_m [16];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  unet_conv_layer_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_we_i        (cfg_we),
    .cfg_addr_i      (cfg_addr),
    .cfg_data_i      (cfg_data),
    .num_layers_i    (num_layers),
    .run_start_i     (run_start),
    .run_abort_i     (run_abort),
    .run_busy_o      (run_busy),
    .run_done_o      (run_done),
    .run_err_o       (run_err),
    .run_aborted_o   (run_aborted),
    .layer_idx_o     (layer_idx),
    .buf_sel_o       (buf_sel),
    .conv_start_o    (conv_start),
    .conv_done_i     (conv_done),
    .height_o        (height),
    .width_o         (width),
    .kernel_size_o   (ksize),
    .padding_o       (pad),
    .filter_offset_o (fofs),
    .in_channels_o   (in_ch),
    .out_channels_o  (out_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, run_busy, 0);
    chk({tag, "_done"}, run_done, 0);
    chk({tag, "_err"}, run_err, 0);
    chk({tag, "_aborted"}, run_aborted, 0);
    chk({tag, "_idx"}, layer_idx, 0);
    chk({tag, "_buf"}, buf_sel, 0);
    chk({tag, "_start"}, conv_start, 0);
    chk({tag, "_cfg"}, {out_ch, in_ch, fofs, pad, ksize, width, height}, 0);
  endtask

  task automatic wr(input int addr, input logic [51:0] data);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = data;
    tbl_m[addr] = data;
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic logic [51:0] rand_desc();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[51:0];
  endfunction

  // n: layer count; abort_layer: layer during whose WAIT abort pulses (-1 none);
  // abort_with_start: abort driven together with run_start; wr_busy: try a table write mid-run.
  task automatic do_run(input string tag, input int n, input int abort_layer,
                        input bit abort_with_start, input bit wr_busy);
    int  since, starts, dones, wcnt, done_at, exp_layers;
    bit  valid;
    valid      = (n >= 1) && (n <= 16);
    exp_layers = !valid ? 0 : ((abort_layer >= 0 && abort_layer < n) ? abort_layer + 1 : n);
    num_layers = 5'(n);
    run_start  = 1'b1;
    run_abort  = abort_with_start;
    since = 0; starts = 0; dones = 0; wcnt = -1; done_at = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      since++;
      run_start = 1'b0;
      run_abort = 1'b0;
      conv_done = 1'b0;
      cfg_we    = 1'b0;
      if (conv_start) begin
        chk({tag, "_start_lat"}, since, (starts == 0) ? 2 : 3);
        if (starts < 16) begin
          chk({tag, "_cfg"}, {out_ch, in_ch, fofs, pad, ksize, width, height}, tbl_m[starts]);
        end
        chk({tag, "_idx"}, layer_idx, starts);
        chk({tag, "_buf"}, buf_sel, starts % 2);
        if (wr_busy && starts == 0) begin
          cfg_we   = 1'b1;
          cfg_addr = 4'd0;
          cfg_data = ~tbl_m[0];
        end
        starts++;
        wcnt = 10;
      end
      if (run_done) begin
        dones++;
        if (done_at < 0) done_at = since;
      end
      if (dones > 0 && !run_busy) break;
      if (wcnt > 0) begin
        wcnt--;
        if (starts - 1 == abort_layer && wcnt == 5) run_abort = 1'b1;
        if (wcnt == 0) begin
          conv_done = 1'b1;
          since = 0;
        end
      end
    end
    chk({tag, "_starts"}, starts, exp_layers);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_err"}, run_err, !valid);
    chk({tag, "_aborted"}, run_aborted, (exp_layers < n) && valid);
    if (valid) begin
      chk({tag, "_last_idx"}, layer_idx, exp_layers - 1);
      chk({tag, "_last_buf"}, buf_sel, (exp_layers - 1) % 2);
    end else begin
      chk({tag, "_bad_done_lat"}, (done_at >= 1 && done_at <= 2), 1);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) wr(i, rand_desc());

    // Basic three-layer run.
    do_run("three", 3, -1, 1'b0, 1'b0);

    // Illegal layer counts.
    do_run("zero", 0, -1, 1'b0, 1'b0);
    do_run("seventeen", 17, -1, 1'b0, 1'b0);

    // Abort during layer 1 of 4.
    do_run("abort", 4, 1, 1'b0, 1'b0);

    // Spurious conv_done in IDLE, abort ignored in IDLE.
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("idle_done_err", run_err, 1);
    run_abort = 1'b1;
    tick();
    run_abort = 1'b0;
    chk("idle_abort_busy", run_busy, 0);
    chk("idle_abort_flag", run_aborted, 1);

    // Start and abort together: start wins.
    do_run("start_abort", 2, -1, 1'b1, 1'b0);

    // Table write while busy is dropped; rerun shows layer 0 unchanged.
    do_run("wr_busy", 1, -1, 1'b0, 1'b1);
    do_run("wr_check", 1, -1, 1'b0, 1'b0);

    // Reset in WAIT.
    num_layers = 5'd2;
    run_start  = 1'b1;
    tick();
    run_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    do_run("after_rst", 2, -1, 1'b0, 1'b0);

    // Fresh random table, full-depth run.
    for (int i = 0; i < 16; i++) wr(i, rand_desc());
    do_run("sixteen", 16, -1, 1'b0, 1'b0);
    do_run("rand", int'($urandom_range(1, 16)), -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
